// File: rtl/result_box_drawer_if.sv
// Command/write bundle between the result-writer control unit and the box drawer.
// The slave side is the drawer: it takes draw commands and drives frame-buffer writes.
interface result_box_drawer_if #(
  parameter int unsigned WIDTH_PIXEL = 4,
  parameter int unsigned WIDTH_ADDR  = 16,
  parameter int unsigned WIDTH_POSI  = 8
);
  logic                   start;
  logic [WIDTH_POSI-1:0]  xpos;
  logic [WIDTH_POSI-1:0]  ypos;
  logic [WIDTH_POSI-1:0]  length;
  logic                   busy;
  logic                   we;
  logic [WIDTH_ADDR-1:0]  addr;
  logic [WIDTH_PIXEL-1:0] wdata;

  modport master (
    output start, xpos, ypos, length,
    input  busy, we, addr, wdata
  );

  modport slave (
    input  start, xpos, ypos, length,
    output busy, we, addr, wdata
  );
endinterface

// File: rtl/result_box_drawer.sv
// Draws one square box outline as single-pixel frame-buffer writes per start pulse.
// Optional macro RESULT_BOX_CLIP_EN suppresses writes to pixels outside the image.
module result_box_drawer #(
  parameter int unsigned            WIDTH_PIXEL = 4,
  parameter int unsigned            WIDTH_ADDR  = 16,
  parameter int unsigned            WIDTH_POSI  = 8,
  parameter int unsigned            IMG_W       = 160,
  parameter int unsigned            IMG_H       = 120,
  parameter logic [WIDTH_PIXEL-1:0] BOX_COLOR   = 4'hF
) (
  input logic              clk,
  input logic              rst,
  result_box_drawer_if.slave bus_io
);

  localparam int unsigned CoordW = WIDTH_POSI + 1;

  typedef logic [CoordW-1:0]     coord_t;
  typedef logic [WIDTH_POSI-1:0] posi_t;

  typedef enum logic [2:0] {
    StIdle,
    StTop,
    StBottom,
    StLeft,
    StRight,
    StFin
  } state_e;

  state_e state_q, state_d;
  posi_t  x_q, x_d, y_q, y_d, len_q, len_d, i_q, i_d;

  logic                   busy_q, busy_d;
  logic                   we_q, we_d;
  logic [WIDTH_ADDR-1:0]  addr_q, addr_d;
  logic [WIDTH_PIXEL-1:0] wdata_q, wdata_d;

  coord_t      i_ext, len_m1, len_m3;
  coord_t      col, row;
  logic        pix;
  logic [31:0] lin;

  assign i_ext  = CoordW'(i_q);
  assign len_m1 = CoordW'(len_q) - CoordW'(1);
  assign len_m3 = CoordW'(len_q) - CoordW'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      len_q   <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      len_q   <= len_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    len_d   = len_q;
    i_d     = i_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          x_d     = bus_io.xpos;
          y_d     = bus_io.ypos;
          len_d   = bus_io.length;
          i_d     = '0;
          state_d = (bus_io.length == '0) ? StFin : StTop;
        end
      end
      StTop: begin
        if (i_ext == len_m1) begin
          i_d     = '0;
          state_d = (len_q == posi_t'(1)) ? StFin : StBottom;
        end else begin
          i_d = i_q + posi_t'(1);
        end
      end
      StBottom: begin
        if (i_ext == len_m1) begin
          i_d     = '0;
          state_d = (len_q == posi_t'(2)) ? StFin : StLeft;
        end else begin
          i_d = i_q + posi_t'(1);
        end
      end
      StLeft: begin
        if (i_ext == len_m3) begin
          i_d     = '0;
          state_d = StRight;
        end else begin
          i_d = i_q + posi_t'(1);
        end
      end
      StRight: begin
        if (i_ext == len_m3) begin
          i_d     = '0;
          state_d = StFin;
        end else begin
          i_d = i_q + posi_t'(1);
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are computed from the step about to be entered.
  always_comb begin
    col = CoordW'(x_d);
    row = CoordW'(y_d);
    pix = 1'b1;
    unique case (state_d)
      StTop: begin
        col = CoordW'(x_d) + CoordW'(i_d);
      end
      StBottom: begin
        col = CoordW'(x_d) + CoordW'(i_d);
        row = CoordW'(y_d) + CoordW'(len_d) - CoordW'(1);
      end
      StLeft: begin
        row = CoordW'(y_d) + CoordW'(1) + CoordW'(i_d);
      end
      StRight: begin
        col = CoordW'(x_d) + CoordW'(len_d) - CoordW'(1);
        row = CoordW'(y_d) + CoordW'(1) + CoordW'(i_d);
      end
      default: pix = 1'b0;
    endcase

    lin    = 32'(row) * IMG_W + 32'(col);
    busy_d = (state_d != StIdle);
`ifdef RESULT_BOX_CLIP_EN
    we_d   = pix && (32'(col) < IMG_W) && (32'(row) < IMG_H);
`else
    we_d   = pix;
`endif
    addr_d  = pix ? lin[WIDTH_ADDR-1:0] : '0;
    wdata_d = pix ? BOX_COLOR : '0;
  end

  assign bus_io.busy  = busy_q;
  assign bus_io.we    = we_q;
  assign bus_io.addr  = addr_q;
  assign bus_io.wdata = wdata_q;

endmodule

// File: tb/tb_result_box_drawer.sv
// Scoreboard bench for result_box_drawer: a box-outline model queues expected writes,
// a monitor pops and compares them on every observed write.
module tb_result_box_drawer;
  localparam int unsigned IMG_W = 160;
  localparam int unsigned IMG_H = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_box_drawer_if #(.WIDTH_PIXEL(4), .WIDTH_ADDR(16), .WIDTH_POSI(8)) bus ();

  result_box_drawer #(
    .WIDTH_PIXEL(4),
    .WIDTH_ADDR (16),
    .WIDTH_POSI (8),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .BOX_COLOR  (4'hF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned exp_q[$];
  int unsigned mon_e;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: every write must match the next expected pixel.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d expected no write", bus.addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 64'(bus.addr), 64'(mon_e));
        chk("write_data", 64'(bus.wdata), 64'(4'hF));
      end
    end else if (bus.we !== 1'b0) begin
      chk("we_known", 64'(bus.we), 64'(0));
    end
  end

  function automatic void push_pix(input int col, input int row);
`ifdef RESULT_BOX_CLIP_EN
    if (col >= int'(IMG_W) || row >= int'(IMG_H)) return;
`endif
    exp_q.push_back(int'((row * int'(IMG_W) + col) % 65536));
  endfunction

  // Outline order: top edge, bottom edge, then left and right columns without corners.
  function automatic int model_box(input int x, input int y, input int l);
    if (l == 0) return 0;
    if (l == 1) begin
      push_pix(x, y);
      return 1;
    end
    for (int i = 0; i < l; i++) push_pix(x + i, y);
    for (int i = 0; i < l; i++) push_pix(x + i, y + l - 1);
    for (int i = 0; i < l - 2; i++) push_pix(x, y + 1 + i);
    for (int i = 0; i < l - 2; i++) push_pix(x + l - 1, y + 1 + i);
    return 4 * l - 4;
  endfunction

  // Called at a negedge with the DUT idle; returns at the first negedge with busy low.
  task automatic run_box(input int x, input int y, input int l,
                         input int repulse_at, input int rst_at);
    int n;
    int busy_cycles;
    bit aborted;
    aborted = 1'b0;
    n = model_box(x, y, l);
    bus.xpos   = 8'(x);
    bus.ypos   = 8'(y);
    bus.length = 8'(l);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'(1));
    busy_cycles = 0;
    for (int c = 1; c <= 600; c++) begin
      if (bus.busy !== 1'b1) break;
      busy_cycles = c;
      bus.xpos   = 8'($urandom);
      bus.ypos   = 8'($urandom);
      bus.length = 8'($urandom);
      bus.start  = (c == repulse_at);
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      if (c == rst_at) begin
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_we", 64'(bus.we), 64'(0));
        chk("rst_pending", 64'(exp_q.size()), 64'(n - rst_at));
        exp_q.delete();
        aborted = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    if (!aborted) begin
      chk("busy_cycles", 64'(busy_cycles), 64'((n == 0) ? 1 : n + 1));
      chk("writes_drained", 64'(exp_q.size()), 64'(0));
      chk("idle_we", 64'(bus.we), 64'(0));
      if (busy_cycles == 600) exp_q.delete();
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.xpos   = '0;
    bus.ypos   = '0;
    bus.length = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_we", 64'(bus.we), 64'(0));
    chk("reset_addr", 64'(bus.addr), 64'(0));
    chk("reset_wdata", 64'(bus.wdata), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_box(10, 20, 4, 0, 0);
    run_box(5, 5, 1, 0, 0);
    run_box(30, 40, 0, 0, 0);
    run_box(158, 0, 4, 0, 0);
    run_box(10, 20, 4, 3, 0);
    run_box(10, 20, 4, 0, 5);
    run_box(50, 60, 2, 0, 0);
    run_box(0, 0, 3, 0, 0);

    for (int t = 0; t < 40; t++) begin
      run_box(int'($urandom_range(0, 170)), int'($urandom_range(0, 130)),
              int'($urandom_range(0, 20)), 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
